// File: rtl/uart_transmitter.sv
// uart_transmitter: serialises parallel words into 8N1 UART frames
// (start bit, data LSB first, optional parity, stop bit) on tx_serial.
// Optional feature macro: UART_TX_PARITY_EN inserts a parity bit between
// the last data bit and the stop bit (even, or odd when PARITY_ODD = 1).
// Without the macro there is no parity state or parity logic.
module uart_transmitter #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_ODD   = 0
) (
    input  logic                 tx_clk,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx_serial,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_MAX = BW'(DATA_BITS - 1);

    // Elaboration-time sanity check on the configuration.
    if (CLKS_PER_BIT < 2 || DATA_BITS < 1 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_cfg_err
        $error("uart_transmitter: illegal parameter combination");
    end

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_STOP
    } state_t;
`endif

    state_t               r_state;
    logic [CW-1:0]        r_clk_cnt;
    logic [BW-1:0]        r_bit_idx;
    logic [DATA_BITS-1:0] r_shreg;
    logic                 r_serial;
    logic                 r_ready;
    logic                 r_busy;
    logic                 r_done;
`ifdef UART_TX_PARITY_EN
    logic                 r_parity;
`endif

    logic w_wrap;
    logic w_accept;

    // A bit period ends on the cycle the clock counter reaches its top value.
    assign w_wrap   = (r_clk_cnt == CNT_MAX);
    assign w_accept = tx_valid && r_ready;

    // Frame sequencer: every output is registered so tx_serial is glitch free.
    always_ff @(posedge tx_clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_clk_cnt <= '0;
            r_bit_idx <= '0;
            r_shreg   <= '0;
            r_serial  <= 1'b1;
            r_ready   <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_parity  <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_clk_cnt <= '0;
                    r_bit_idx <= '0;
                    r_serial  <= 1'b1;
                    if (w_accept) begin
                        // Start bit goes out on the accept edge itself.
                        r_shreg  <= tx_data;
                        r_serial <= 1'b0;
                        r_ready  <= 1'b0;
                        r_busy   <= 1'b1;
                        r_state  <= S_START;
`ifdef UART_TX_PARITY_EN
                        r_parity <= (^tx_data) ^ (PARITY_ODD != 0);
`endif
                    end
                end
                S_START: begin
                    if (w_wrap) begin
                        r_clk_cnt <= '0;
                        r_serial  <= r_shreg[0];
                        r_shreg   <= r_shreg >> 1;
                        r_state   <= S_DATA;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (w_wrap) begin
                        r_clk_cnt <= '0;
                        if (r_bit_idx == BIT_MAX) begin
                            r_bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
                            r_serial  <= r_parity;
                            r_state   <= S_PARITY;
`else
                            r_serial  <= 1'b1;
                            r_state   <= S_STOP;
`endif
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                            r_serial  <= r_shreg[0];
                            r_shreg   <= r_shreg >> 1;
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                    if (w_wrap) begin
                        r_clk_cnt <= '0;
                        r_serial  <= 1'b1;
                        r_state   <= S_STOP;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end
`endif
                S_STOP: begin
                    if (w_wrap) begin
                        r_clk_cnt <= '0;
                        r_done    <= 1'b1;
                        r_ready   <= 1'b1;
                        r_busy    <= 1'b0;
                        r_state   <= S_IDLE;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end
                default: begin
                    r_clk_cnt <= '0;
                    r_bit_idx <= '0;
                    r_serial  <= 1'b1;
                    r_ready   <= 1'b1;
                    r_busy    <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

    assign tx_ready  = r_ready;
    assign tx_serial = r_serial;
    assign tx_busy   = r_busy;
    assign tx_done   = r_done;

endmodule

// File: tb/tb_uart_transmitter.sv
// tb_uart_transmitter: randomized and directed frames checked against a
// frame-level model (bit n of the frame is held for cycles n*CPB..n*CPB+CPB-1
// after the accept edge).
module tb_uart_transmitter;

    localparam int CPB  = 16;
    localparam int DB   = 8;
    localparam int PODD = 0;
`ifdef UART_TX_PARITY_EN
    localparam int NB = DB + 3;
`else
    localparam int NB = DB + 2;
`endif
    localparam int FLEN = NB * CPB;

    logic          tx_clk = 1'b0;
    logic          reset;
    logic [DB-1:0] tx_data;
    logic          tx_valid;
    logic          tx_ready;
    logic          tx_serial;
    logic          tx_busy;
    logic          tx_done;

    int checks = 0;
    int errors = 0;

    uart_transmitter #(
        .CLKS_PER_BIT(CPB),
        .DATA_BITS   (DB),
        .PARITY_ODD  (PODD)
    ) dut (
        .tx_clk   (tx_clk),
        .reset    (reset),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx_serial(tx_serial),
        .tx_busy  (tx_busy),
        .tx_done  (tx_done)
    );

    always #5 tx_clk = ~tx_clk;

    // Expected line level k cycles after the accept edge.
    function automatic logic exp_bit(input logic [DB-1:0] d, input int k);
        int b;
        b = k / CPB;
        if (b == 0) return 1'b0;
        if (b <= DB) return d[b-1];
`ifdef UART_TX_PARITY_EN
        if (b == DB + 1) return (^d) ^ (PODD != 0);
`endif
        return 1'b1;
    endfunction

    // Wait for ready, present d, and return right after the accept edge.
    task automatic accept(input logic [DB-1:0] d);
        int n;
        n = 0;
        @(negedge tx_clk);
        while (!tx_ready && n < 1000) begin
            @(negedge tx_clk);
            n++;
        end
        checks++;
        if (!tx_ready) begin
            errors++;
            $display("FAIL accept_timeout ready=%b required=1", tx_ready);
        end
        tx_data  = d;
        tx_valid = 1'b1;
        @(posedge tx_clk);
    endtask

    // Check a whole frame starting at the negedge after the accept edge.
    // mode 0: drop valid; mode 1: keep valid high and present nd;
    // mode 2: drop valid, then inject 0xFF with valid during data bit 3.
    task automatic check_frame(input logic [DB-1:0] d, input int mode,
                               input logic [DB-1:0] nd, output logic [15:0] samp);
        logic [DB-1:0] dec;
        logic          e;
        dec  = '0;
        samp = '0;
        for (int k = 0; k <= FLEN; k++) begin
            @(negedge tx_clk);
            if (k == 0) begin
                if (mode == 1) tx_data = nd;
                else tx_valid = 1'b0;
            end
            if (mode == 2 && k == 4 * CPB + 6) begin
                tx_valid = 1'b1;
                tx_data  = 8'hFF;
            end
            checks++;
            if (k < FLEN) begin
                e = exp_bit(d, k);
                if ({tx_serial, tx_busy, tx_ready, tx_done} !== {e, 3'b100}) begin
                    errors++;
                    $display("FAIL frame_%02h k=%0d ser/busy/rdy/done=%b%b%b%b required=%b100",
                             d, k, tx_serial, tx_busy, tx_ready, tx_done, e);
                end
                if (k % CPB == CPB / 2) begin
                    samp[k / CPB] = tx_serial;
                    if (k / CPB >= 1 && k / CPB <= DB) dec[k / CPB - 1] = tx_serial;
                end
            end else begin
                if ({tx_serial, tx_busy, tx_ready, tx_done} !== 4'b1011) begin
                    errors++;
                    $display("FAIL done_%02h ser/busy/rdy/done=%b%b%b%b required=1011",
                             d, tx_serial, tx_busy, tx_ready, tx_done);
                end
                if (mode == 2) tx_valid = 1'b0;
            end
        end
        checks++;
        if (dec !== d) begin
            errors++;
            $display("FAIL decode got=%02h required=%02h", dec, d);
        end
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        tx_valid = 1'b0;
        tx_data  = '0;
        repeat (2) @(posedge tx_clk);
        #1;
        checks++;
        if ({tx_serial, tx_ready, tx_busy, tx_done} !== 4'b1100) begin
            errors++;
            $display("FAIL reset_state got=%b%b%b%b required=1100",
                     tx_serial, tx_ready, tx_busy, tx_done);
        end
        @(negedge tx_clk);
        reset = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge tx_clk);
            checks++;
            if ({tx_serial, tx_ready, tx_busy, tx_done} !== 4'b1100) begin
                errors++;
                $display("FAIL idle_stable cyc=%0d got=%b%b%b%b required=1100",
                         i, tx_serial, tx_ready, tx_busy, tx_done);
            end
        end
    endtask

    task automatic test_send_aa();
        logic [15:0] s;
        accept(8'hAA);
        check_frame(8'hAA, 0, 8'h00, s);
`ifndef UART_TX_PARITY_EN
        checks++;
        if (s[9:0] !== 10'b1101010100) begin
            errors++;
            $display("FAIL aa_midbit got=%b required=1101010100", s[9:0]);
        end
`endif
        @(negedge tx_clk);
        checks++;
        if ({tx_serial, tx_done} !== 2'b10) begin
            errors++;
            $display("FAIL done_one_cycle ser/done=%b%b required=10", tx_serial, tx_done);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] s;
        accept(8'h55);
        check_frame(8'h55, 1, 8'h0F, s);
        // Second accept happens on the next edge: its start bit lands FLEN+1 cycles in.
        check_frame(8'h0F, 0, 8'h00, s);
    endtask

    task automatic test_ignore_busy();
        logic [15:0] s;
        accept(8'h3C);
        check_frame(8'h3C, 2, 8'h00, s);
        repeat (3) begin
            @(negedge tx_clk);
            checks++;
            if ({tx_serial, tx_busy} !== 2'b10) begin
                errors++;
                $display("FAIL no_queue ser/busy=%b%b required=10", tx_serial, tx_busy);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] s;
        int          dones;
        accept(8'h81);
        tx_valid = 1'b0;
        repeat (70) @(negedge tx_clk);
        reset = 1'b1;
        #1;
        checks++;
        if ({tx_serial, tx_ready, tx_busy, tx_done} !== 4'b1100) begin
            errors++;
            $display("FAIL reset_mid got=%b%b%b%b required=1100",
                     tx_serial, tx_ready, tx_busy, tx_done);
        end
        repeat (3) @(negedge tx_clk);
        reset = 1'b0;
        dones = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge tx_clk);
            if (tx_done || !tx_serial) dones++;
        end
        checks++;
        if (dones !== 0) begin
            errors++;
            $display("FAIL abort_quiet events=%0d required=0", dones);
        end
        accept(8'h81);
        check_frame(8'h81, 0, 8'h00, s);
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        logic [15:0] s;
        accept(8'h07);
        check_frame(8'h07, 0, 8'h00, s);
        checks++;
        if (s[DB+1] !== 1'b1) begin
            errors++;
            $display("FAIL parity_07 got=%b required=1", s[DB+1]);
        end
        accept(8'h03);
        check_frame(8'h03, 0, 8'h00, s);
        checks++;
        if (s[DB+1] !== 1'b0) begin
            errors++;
            $display("FAIL parity_03 got=%b required=0", s[DB+1]);
        end
    endtask
`endif

    task automatic test_random();
        logic [15:0]   s;
        logic [DB-1:0] d;
        logic [DB-1:0] d2;
        for (int i = 0; i < 8; i++) begin
            d = DB'($urandom);
            repeat ($urandom_range(0, 3)) @(negedge tx_clk);
            accept(d);
            if ($urandom_range(0, 1) == 1) begin
                d2 = DB'($urandom);
                check_frame(d, 1, d2, s);
                check_frame(d2, 0, 8'h00, s);
            end else begin
                check_frame(d, 0, 8'h00, s);
            end
        end
    endtask

    initial begin
        reset    = 1'b1;
        tx_valid = 1'b0;
        tx_data  = '0;
        test_reset();
        test_send_aa();
        test_back_to_back();
        test_ignore_busy();
        test_reset_mid();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
